branch_history_table: RTL
=========================

// Module: branch_history_table
// PURPOSE
//  Gshare direction predictor; sits beside the BTB in IF. BTB supplies hit/type/target.
//  This block supplies the taken/not-taken decision for conditional branches, using 2-bit
//  saturating counters indexed by PC xor global history. It is trained by branches resolved in EX.
//  It also keeps branch and mispredict statistics counters.
// PARAMETERS
//  INDEX_WIDTH   6      log2(counter entries); table = 2**INDEX_WIDTH x 2 bits
//  GHR_WIDTH     6      global history bits; must satisfy 1 <= GHR_WIDTH <= INDEX_WIDTH
//  COUNTER_INIT  2'b01  counter value written during init (weakly not-taken)
// PORTS
//  clk            in   1   clock, all state on posedge
//  rst            in   1   synchronous, active-high reset
//  IF_pc          in   32  fetch PC
//  hit            in   1   BTB hit for IF_pc
//  IF_Branch      in   1   BTB says conditional branch
//  IF_Jump        in   1   BTB says unconditional jump
//  predict_taken  out  1   redirect fetch to BTB target
//  pred_index     out  INDEX_WIDTH  table index used; carried by pipeline to EX
//  EX_valid       in   1   EX holds a valid resolved instruction this cycle
//  EX_Branch      in   1   EX instruction is a conditional branch
//  EX_taken       in   1   actual outcome
//  EX_mispredict  in   1   prediction made in IF was wrong
//  EX_index       in   INDEX_WIDTH  pred_index captured for this branch
//  init_busy      out  1   table initialisation in progress
//  branch_count   out  32  resolved conditional branches since reset
//  mispredict_count out 32 resolved mispredictions since reset
// BEHAVIOUR
//  Reset (rst=1 at posedge): state<=INIT, init_ptr<=0, ghr<=0, both counts<=0.
//   Table contents are not touched by rst itself.
//  FSM INIT: each cycle write COUNTER_INIT to entry init_ptr; init_ptr++.
//   On the cycle init_ptr==2**INDEX_WIDTH-1, write it and go to READY.
//   init_busy=1 for exactly 2**INDEX_WIDTH cycles after reset release.
//  FSM READY: terminal until rst. rst asserted mid-INIT restarts at ptr 0.
//  Index: idx = IF_pc[INDEX_WIDTH+1:2] ^ {zero-pad, ghr}. pred_index=idx (combinational).
//  predict_taken (combinational): 0 while init_busy.
//   Otherwise hit&&IF_Jump -> 1; hit&&IF_Branch -> table[idx][1]; else 0.
//   If IF_Jump and IF_Branch are both set, IF_Jump wins.
//  Update: at posedge, when READY && EX_valid && EX_Branch:
//   table[EX_index] +1 if EX_taken, saturating at 2'b11; -1 if not taken, saturating at 2'b00.
//   ghr <= {ghr[GHR_WIDTH-2:0], EX_taken}; branch_count++.
//   mispredict_count++ if EX_mispredict.
//  Jumps and non-branches (EX_Branch=0) never touch the table, ghr or counts.
//  Updates arriving during INIT are dropped entirely; state is unchanged.
//  Same-cycle read/write of one entry: the read sees the old value (no bypass).
//   The new value is visible the next cycle. Same for ghr: idx uses the pre-update ghr.
//  Counts are 32-bit and wrap 0xFFFFFFFF -> 0. History is non-speculative.
//  Wrong-path branches never reach EX_valid, so no recovery is needed.
//  Table is a single-write-port array: INIT write and update write are mutually exclusive by state.
// TESTING
//  Init: pulse rst 1 cycle -> init_busy=1 for 64 cycles, then 0.
//   predict_taken=0 throughout, even with hit=1, IF_Jump=1.
//  Saturation: after init, 3 taken updates at EX_index=5 -> counter 11.
//   A 4th stays 11; 4 not-taken -> 00, stays 00. predict_taken tracks bit1.
//  Gshare: IF_pc=0x00000014 (pc idx 5), ghr=0 -> pred_index=5.
//   After taken,taken resolves, ghr=0b000011 -> pred_index=6.
//  Type select: hit=1, IF_Jump=1 -> predict_taken=1.
//   hit=0, IF_Branch=1 -> 0. EX_Branch=0 update -> table/ghr/counts unchanged.
//  Stats: 10 branch resolves, 3 with EX_mispredict -> branch_count=10, mispredict_count=3.
//   Update during INIT -> counts stay 0.
//  Reset mid-op: rst at init cycle 30 -> init_busy stays 1 for 64 cycles from release.
//   ghr=0, counts=0.

Source files
------------

// File: rtl/branch_history_table_if.sv
// Purpose: fetch-side prediction and EX-side training signals for the gshare predictor.
// Latency: pure wiring, no state.
// Backpressure: none; every signal is a single-cycle strobe or a level.
// Ports (slave = predictor view):
//   in : IF_pc, hit, IF_Branch, IF_Jump, EX_valid, EX_Branch, EX_taken, EX_mispredict, EX_index
//   out: predict_taken, pred_index, init_busy, branch_count, mispredict_count
interface branch_history_table_if #(
  parameter int INDEX_WIDTH = 6
);
  // Fetch side
  logic [31:0]            IF_pc;
  logic                   hit;
  logic                   IF_Branch;
  logic                   IF_Jump;
  logic                   predict_taken;
  logic [INDEX_WIDTH-1:0] pred_index;
  // Resolve side
  logic                   EX_valid;
  logic                   EX_Branch;
  logic                   EX_taken;
  logic                   EX_mispredict;
  logic [INDEX_WIDTH-1:0] EX_index;
  // Status
  logic                   init_busy;
  logic [31:0]            branch_count;
  logic [31:0]            mispredict_count;

  modport master (
    output IF_pc, hit, IF_Branch, IF_Jump,
    output EX_valid, EX_Branch, EX_taken, EX_mispredict, EX_index,
    input  predict_taken, pred_index, init_busy, branch_count, mispredict_count
  );

  modport slave (
    input  IF_pc, hit, IF_Branch, IF_Jump,
    input  EX_valid, EX_Branch, EX_taken, EX_mispredict, EX_index,
    output predict_taken, pred_index, init_busy, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_history_table.sv
// Purpose: gshare direction predictor (2-bit counters indexed by PC xor global history) + branch stats.
// Latency: prediction is combinational in IF; a training update is visible from the next cycle.
// Backpressure: none; updates are never stalled, and are dropped while the table initialises.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   io_bht   : slave side of branch_history_table_if (fetch lookup, EX training, status/statistics)
module branch_history_table #(
  parameter int         INDEX_WIDTH  = 6,
  parameter int         GHR_WIDTH    = 6,
  parameter logic [1:0] COUNTER_INIT = 2'b01
) (
  input  logic                    clk,
  input  logic                    rst,
  branch_history_table_if.slave   io_bht
);

  localparam int ENTRIES = 2**INDEX_WIDTH;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [INDEX_WIDTH-1:0] r_init_ptr;
  logic [GHR_WIDTH-1:0]   r_ghr;
  logic [GHR_WIDTH-1:0]   w_ghr_nxt;
  logic [1:0]             r_table [ENTRIES];
  logic [31:0]            r_branch_count;
  logic [31:0]            r_mispredict_count;

  logic                   w_init_busy;
  logic                   w_init_we;
  logic                   w_upd_en;
  logic [INDEX_WIDTH-1:0] w_idx;
  logic [1:0]             w_pred_ctr;
  logic [1:0]             w_ctr_old;
  logic [1:0]             w_ctr_new;
  logic                   w_predict_taken;
  logic                   w_unused_pc;

  // PC bits outside the index field do not take part in the lookup.
  assign w_unused_pc = ^{io_bht.IF_pc[31:INDEX_WIDTH+2], io_bht.IF_pc[1:0]};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (r_init_ptr == '1) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Init writes and training writes share the single table write port;
  // the state makes them mutually exclusive.
  always_comb begin
    w_init_busy = (r_state == ST_INIT);
    w_init_we   = w_init_busy && !rst;
    w_upd_en    = !w_init_busy && !rst && io_bht.EX_valid && io_bht.EX_Branch;
  end

  // ---------------- init pointer ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_ptr <= '0;
    end else if (w_init_we) begin
      r_init_ptr <= r_init_ptr + 1'b1;
    end
  end

  // ---------------- counter table (not reset; rebuilt by init sweep) ----------------
  assign w_ctr_old = r_table[io_bht.EX_index];

  always_comb begin
    w_ctr_new = w_ctr_old;
    if (io_bht.EX_taken) begin
      if (w_ctr_old != 2'b11) w_ctr_new = w_ctr_old + 2'b01;
    end else begin
      if (w_ctr_old != 2'b00) w_ctr_new = w_ctr_old - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_table[r_init_ptr] <= COUNTER_INIT;
    end else if (w_upd_en) begin
      r_table[io_bht.EX_index] <= w_ctr_new;
    end
  end

  // ---------------- global history (non-speculative) ----------------
  generate
    if (GHR_WIDTH == 1) begin : g_ghr_one
      assign w_ghr_nxt = io_bht.EX_taken;
    end else begin : g_ghr_shift
      assign w_ghr_nxt = {r_ghr[GHR_WIDTH-2:0], io_bht.EX_taken};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_upd_en) begin
      r_ghr <= w_ghr_nxt;
    end
  end

  // ---------------- statistics (wrap naturally at 32 bits) ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_upd_en) begin
      r_branch_count <= r_branch_count + 32'd1;
      if (io_bht.EX_mispredict) r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  // ---------------- lookup ----------------
  // Reads use the pre-update table and history: no bypass from a same-cycle write.
  assign w_idx      = io_bht.IF_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(r_ghr);
  assign w_pred_ctr = r_table[w_idx];

  // Unconditional jumps win over conditional branches when the BTB flags both.
  always_comb begin
    w_predict_taken = 1'b0;
    if (!w_init_busy && io_bht.hit) begin
      if (io_bht.IF_Jump)        w_predict_taken = 1'b1;
      else if (io_bht.IF_Branch) w_predict_taken = w_pred_ctr[1];
    end
  end

  assign io_bht.predict_taken    = w_predict_taken;
  assign io_bht.pred_index       = w_idx;
  assign io_bht.init_busy        = w_init_busy;
  assign io_bht.branch_count     = r_branch_count;
  assign io_bht.mispredict_count = r_mispredict_count;

endmodule
